// File: rtl/pixel_buffer_sink_if.sv
// Shader -> pixel buffer -> frame buffer SRAM bus types and interface.
// PB_STALL_STATS_EN adds the stall_cycles counter signal to the interface.

package pixel_buffer_sink_pkg;
  localparam int unsigned PIXEL_ID_W = 19;
  localparam int unsigned COLOR_W    = 16;

  typedef logic [PIXEL_ID_W-1:0] pixel_id_t;
  typedef logic [COLOR_W-1:0]    color_t;

  typedef struct packed {
    color_t    color;
    pixel_id_t pixel_id;
  } pixel_buffer_entry_t;
endpackage

interface pixel_buffer_sink_if;
  import pixel_buffer_sink_pkg::*;

  logic                pb_we;
  pixel_buffer_entry_t pb_data_in;
  logic                pb_full;
  logic                clear_start;
  logic                sram_we;
  pixel_id_t           sram_addr;
  color_t              sram_wdata;
  logic                sram_ack;
  logic                frame_done;
  logic                overflow;
`ifdef PB_STALL_STATS_EN
  logic [31:0]         stall_cycles;

  modport master (
    output pb_we, pb_data_in, clear_start, sram_ack,
    input  pb_full, sram_we, sram_addr, sram_wdata, frame_done, overflow, stall_cycles
  );

  modport slave (
    input  pb_we, pb_data_in, clear_start, sram_ack,
    output pb_full, sram_we, sram_addr, sram_wdata, frame_done, overflow, stall_cycles
  );
`else
  modport master (
    output pb_we, pb_data_in, clear_start, sram_ack,
    input  pb_full, sram_we, sram_addr, sram_wdata, frame_done, overflow
  );

  modport slave (
    input  pb_we, pb_data_in, clear_start, sram_ack,
    output pb_full, sram_we, sram_addr, sram_wdata, frame_done, overflow
  );
`endif
endinterface

// File: rtl/pixel_buffer_sink.sv
// Pixel buffer sink: FIFO of shader pixel writes drained to the frame buffer
// SRAM over req/ack, frame completion pulse, optional background clear sweep.
// Optional macro PB_STALL_STATS_EN adds a saturating stall_cycles counter.

module pixel_buffer_sink
  import pixel_buffer_sink_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_PIXELS = 307200,
  parameter color_t      BG_COLOR   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  pixel_buffer_sink_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PIX_W = $clog2(NUM_PIXELS + 1);

  localparam pixel_id_t        LAST_ADDR = PIXEL_ID_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                clr_pend_q, clr_pend_d;
  pixel_id_t           clr_addr_q, clr_addr_d;

  pixel_buffer_entry_t mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic                frame_done_q;
  logic                overflow_q;

  logic                empty;
  logic                pb_full;
  logic                sram_we;
  logic                push;
  logic                pop;
  pixel_buffer_entry_t head;

  // Back-pressure and request decode, all from registered state
  assign empty   = (count_q == '0);
  assign pb_full = (count_q == FULL_CNT) | (state_q == ST_CLEAR) | clr_pend_q;
  assign sram_we = (state_q == ST_CLEAR) | ~empty;
  assign push    = bus.pb_we & ~pb_full;
  assign pop     = (state_q == ST_RUN) & ~empty & bus.sram_ack;
  assign head    = mem[rd_ptr_q];

  assign bus.pb_full    = pb_full;
  assign bus.sram_we    = sram_we;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

  // SRAM write port mux: clear sweep, FIFO head, or idle zeros
  always_comb begin
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      bus.sram_addr  = clr_addr_q;
      bus.sram_wdata = BG_COLOR;
    end else if (!empty) begin
      bus.sram_addr  = head.pixel_id;
      bus.sram_wdata = head.color;
    end
  end

  // FSM next-state: pending clear waits for the FIFO to drain
  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_RUN: begin
        if (clr_pend_q) begin
          if (empty) begin
            state_d    = ST_CLEAR;
            clr_pend_d = 1'b0;
          end
        end else if (bus.clear_start) begin
          if (empty) state_d = ST_CLEAR;
          else       clr_pend_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (bus.sram_ack) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = ST_RUN;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // FIFO storage; contents are don't-care until pointed to
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.pb_data_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Drained-pixel counter and frame completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) begin
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
      end
    end
  end

  // Sticky flag for writes the shader issued while we were full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    overflow_q <= 1'b0;
    else if (bus.pb_we & pb_full) overflow_q <= 1'b1;
  end

`ifdef PB_STALL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [1:0]  stall_inc;
  logic        run_stall;

  assign run_stall        = (state_q == ST_RUN) & sram_we & ~bus.sram_ack;
  assign stall_inc        = 2'(run_stall) + 2'(pb_full);
  assign bus.stall_cycles = stall_cycles_q;

  // Saturating stall counter, restarted at each frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if (frame_done_q) begin
      stall_cycles_q <= '0;
    end else if (stall_cycles_q > (32'hFFFF_FFFF - 32'(stall_inc))) begin
      stall_cycles_q <= 32'hFFFF_FFFF;
    end else begin
      stall_cycles_q <= stall_cycles_q + 32'(stall_inc);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_buffer_sink.sv
// Directed bench for pixel_buffer_sink with a queue-based reference model.

module tb_pixel_buffer_sink;
  import pixel_buffer_sink_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NPIX  = 8;
  localparam color_t      BG    = 16'h07E0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pixel_buffer_sink_if pbif ();

  pixel_buffer_sink #(
    .DEPTH     (DEPTH),
    .NUM_PIXELS(NPIX),
    .BG_COLOR  (BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pbif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue, clear sweep as an address, frame as a pixel tally
  logic [34:0] m_q [$];
  bit          m_clear = 1'b0;
  bit          m_pend  = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_fd    = 1'b0;
  int unsigned m_clr_addr = 0;
  int unsigned m_pix      = 0;
  bit          m_full_now;
  int unsigned m_occ;
  bit          m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_clear    = 1'b0;
      m_pend     = 1'b0;
      m_ovf      = 1'b0;
      m_fd       = 1'b0;
      m_clr_addr = 0;
      m_pix      = 0;
    end else begin
      m_occ      = m_q.size();
      m_full_now = (m_occ == DEPTH) || m_clear || m_pend;
      m_acc      = pbif.pb_we && !m_full_now;
      if (pbif.pb_we && m_full_now) m_ovf = 1'b1;
      m_fd = 1'b0;
      if (m_clear) begin
        if (pbif.sram_ack) begin
          if (m_clr_addr == NPIX - 1) begin
            m_clear    = 1'b0;
            m_clr_addr = 0;
          end else begin
            m_clr_addr++;
          end
        end
      end else begin
        if (m_occ != 0 && pbif.sram_ack) begin
          void'(m_q.pop_front());
          m_pix++;
          if (m_pix == NPIX) begin
            m_pix = 0;
            m_fd  = 1'b1;
          end
        end
        if (m_pend) begin
          if (m_occ == 0) begin
            m_clear = 1'b1;
            m_pend  = 1'b0;
          end
        end else if (pbif.clear_start) begin
          if (m_occ == 0) m_clear = 1'b1;
          else            m_pend  = 1'b1;
        end
      end
      if (m_acc) m_q.push_back(pbif.pb_data_in);
    end
  end

  // Log of accepted SRAM writes and frame_done pulses as seen on the bus
  logic [34:0] wr_log [$];
  int          fd_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (pbif.sram_we && pbif.sram_ack) wr_log.push_back({pbif.sram_wdata, pbif.sram_addr});
      if (pbif.frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every bus output against the model
  task automatic compare_cycle();
    bit          e_full;
    bit          e_we;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    e_full = (m_q.size() == DEPTH) || m_clear || m_pend;
    e_we   = m_clear || (m_q.size() != 0);
    check("pb_full",    64'(pbif.pb_full),    64'(e_full));
    check("sram_we",    64'(pbif.sram_we),    64'(e_we));
    check("frame_done", 64'(pbif.frame_done), 64'(m_fd));
    check("overflow",   64'(pbif.overflow),   64'(m_ovf));
    if (e_we) begin
      if (m_clear) begin
        e_addr = 64'(m_clr_addr);
        e_data = 64'(BG);
      end else begin
        e_addr = 64'(m_q[0][18:0]);
        e_data = 64'(m_q[0][34:19]);
      end
      check("sram_addr",  64'(pbif.sram_addr),  e_addr);
      check("sram_wdata", 64'(pbif.sram_wdata), e_data);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic check_log(input string name, input int base, input logic [34:0] exp[$]);
    int got;
    got = wr_log.size() - base;
    check({name, " count"}, 64'(got), 64'(exp.size()));
    if (got == exp.size())
      foreach (exp[i]) check(name, 64'(wr_log[base + i]), 64'(exp[i]));
  endtask

  logic [34:0] exp_q [$];
  int          base;
  int          fdb;
  bit          full_seen;

  initial begin
    pbif.pb_we       = 1'b0;
    pbif.pb_data_in  = '0;
    pbif.clear_start = 1'b0;
    pbif.sram_ack    = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst pb_full",    64'(pbif.pb_full),    64'd0);
    check("rst sram_we",    64'(pbif.sram_we),    64'd0);
    check("rst overflow",   64'(pbif.overflow),   64'd0);
    check("rst frame_done", 64'(pbif.frame_done), 64'd0);
    rst = 1'b1;
    tick();

    // 1: ack tied high, one pixel per cycle, one frame
    pbif.sram_ack = 1'b1;
    base = wr_log.size();
    fdb  = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.pb_data_in = {16'hF800, 19'(i)};
      tick();
      check("t1 latency we", 64'(pbif.sram_we), 64'd1);
      check("t1 latency addr", 64'(pbif.sram_addr), 64'(i));
    end
    pbif.pb_we = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({16'hF800, 19'(i)});
    check_log("t1 writes", base, exp_q);
    check("t1 frame_done pulses", 64'(fd_cnt - fdb), 64'd1);

    // 2: ack low, fifth push overflows, then drain exactly four
    pbif.sram_ack = 1'b0;
    base = wr_log.size();
    for (int i = 0; i < 5; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.pb_data_in = {16'h001F, 19'(16 + i)};
      tick();
    end
    pbif.pb_we = 1'b0;
    check("t2 overflow", 64'(pbif.overflow), 64'd1);
    check("t2 pb_full",  64'(pbif.pb_full),  64'd1);
    check("t2 head addr", 64'(pbif.sram_addr), 64'd16);
    repeat (3) tick();
    check("t2 held addr", 64'(pbif.sram_addr),  64'd16);
    check("t2 held data", 64'(pbif.sram_wdata), 64'h001F);
    pbif.sram_ack = 1'b1;
    repeat (6) tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h001F, 19'(16 + i)});
    check_log("t2 writes", base, exp_q);

    // 3: clear with empty FIFO
    base = wr_log.size();
    fdb  = fd_cnt;
    pbif.clear_start = 1'b1;
    tick();
    pbif.clear_start = 1'b0;
    check("t3 pb_full",   64'(pbif.pb_full),    64'd1);
    check("t3 first addr", 64'(pbif.sram_addr), 64'd0);
    check("t3 bg data",   64'(pbif.sram_wdata), 64'(BG));
    repeat (10) tick();
    check("t3 pb_full after", 64'(pbif.pb_full), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({BG, 19'(i)});
    check_log("t3 writes", base, exp_q);
    check("t3 no frame_done", 64'(fd_cnt - fdb), 64'd0);

    // 4: clear requested with three entries queued
    pbif.sram_ack = 1'b0;
    base = wr_log.size();
    for (int i = 0; i < 3; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.pb_data_in = {16'hABCD, 19'(40 + i)};
      tick();
    end
    pbif.pb_we       = 1'b0;
    pbif.clear_start = 1'b1;
    tick();
    pbif.clear_start = 1'b0;
    check("t4 pend full", 64'(pbif.pb_full),   64'd1);
    check("t4 head addr", 64'(pbif.sram_addr), 64'd40);
    pbif.sram_ack = 1'b1;
    repeat (15) tick();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({16'hABCD, 19'(40 + i)});
    for (int i = 0; i < 8; i++) exp_q.push_back({BG, 19'(i)});
    check_log("t4 writes", base, exp_q);

    // 5: three queued, simultaneous push+pop for ten cycles
    pbif.sram_ack = 1'b0;
    base = wr_log.size();
    fdb  = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.pb_data_in = {16'h1234, 19'(50 + i)};
      tick();
    end
    full_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.sram_ack   = 1'b1;
      pbif.pb_data_in = {16'h1234, 19'(53 + i)};
      tick();
      if (pbif.pb_full) full_seen = 1'b1;
    end
    pbif.pb_we = 1'b0;
    check("t5 pb_full seen", 64'(full_seen), 64'd0);
    check("t5 occupancy 3 head", 64'(pbif.sram_addr), 64'd60);
    repeat (5) tick();
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back({16'h1234, 19'(50 + i)});
    check_log("t5 writes", base, exp_q);
    check("t5 frame_done pulses", 64'(fd_cnt - fdb), 64'd2);

    // 6: asynchronous reset in the middle of a clear sweep
    pbif.clear_start = 1'b1;
    tick();
    pbif.clear_start = 1'b0;
    repeat (4) tick();
    check("t6 clr addr", 64'(pbif.sram_addr), 64'd4);
    #2 rst = 1'b0;
    #1;
    check("t6 rst pb_full",   64'(pbif.pb_full),   64'd0);
    check("t6 rst sram_we",   64'(pbif.sram_we),   64'd0);
    check("t6 rst sram_addr", 64'(pbif.sram_addr), 64'd0);
    check("t6 rst overflow",  64'(pbif.overflow),  64'd0);
`ifdef PB_STALL_STATS_EN
    check("t6 rst stall_cycles", 64'(pbif.stall_cycles), 64'd0);
`endif
    tick();
    rst = 1'b1;
    base = wr_log.size();
    for (int i = 0; i < 2; i++) begin
      pbif.pb_we      = 1'b1;
      pbif.pb_data_in = {16'h5555, 19'(70 + i)};
      tick();
    end
    pbif.pb_we = 1'b0;
    repeat (4) tick();
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back({16'h5555, 19'(70 + i)});
    check_log("t6 writes", base, exp_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
